demux_dispatch_fifo: RTL and testbench

//  Upstream feeder for the 1-to-8 demux stage. Accepts {data bit, 3-bit destination} requests

---
 rtl/demux_dispatch_fifo.sv | 75 +++++++
 tb/tb_demux_dispatch_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_fifo.sv
// demux_dispatch_fifo: buffers {d, sel} requests and replays each as a one-cycle d pulse with held selects.
// Optional DEMUX_DISPATCH_STATS_EN adds a saturating dispatch_cnt[7:0] output.
module demux_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_d,
  input  logic [2:0]               in_sel,
  output logic                     d,
  output logic                     s0,
  output logic                     s1,
  output logic                     s2,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef DEMUX_DISPATCH_STATS_EN
  ,
  output logic [7:0]               dispatch_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [3:0] GLAST = GAP_CYCLES > 0 ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [1:0] state;
  logic [3:0] gcnt;
  logic push, pop, go;
  // ready is gated by rst so nothing can be accepted while reset is held
  assign in_ready = !rst && count != FULL;
  assign push = in_valid && in_ready;
  assign go = state == IDLE || (state == DRIVE && GAP_CYCLES == 0) || (state == GAP && gcnt == 4'd0);
  assign pop = go && count != '0;
  assign busy = count != '0 || state != IDLE;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_d, in_sel};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      state <= IDLE;
      gcnt <= '0;
      d <= 1'b0;
      {s2, s1, s0} <= 3'b000;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (pop) begin
        state <= DRIVE;
        d <= mem[rptr][3];
        {s2, s1, s0} <= mem[rptr][2:0];
      end else if (state == DRIVE) begin
        d <= 1'b0;
        state <= GAP_CYCLES > 0 ? GAP : IDLE;
        gcnt <= GLAST;
      end else if (state == GAP) begin
        if (gcnt == 4'd0) state <= IDLE;
        else gcnt <= gcnt - 4'd1;
      end
    end
  end
`ifdef DEMUX_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) dispatch_cnt <= '0;
    else if (pop && dispatch_cnt != 8'hff) dispatch_cnt <= dispatch_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_demux_dispatch_fifo.sv
// tb_demux_dispatch_fifo: directed bench over three gap settings (1, 0, 4) with DEPTH=4.
module tb_demux_dispatch_fifo;
  logic clk = 0, rst = 1, in_d = 0;
  logic [2:0] in_sel = 0;
  logic v[3], rdy[3], dd[3], s0o[3], s1o[3], s2o[3], bz[3];
  logic [2:0] cnt[3];
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [7:0] dc[3];
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    demux_dispatch_fifo #(.DEPTH(4), .GAP_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 4)) u (
      .clk(clk), .rst(rst), .in_valid(v[g]), .in_ready(rdy[g]), .in_d(in_d), .in_sel(in_sel),
      .d(dd[g]), .s0(s0o[g]), .s1(s1o[g]), .s2(s2o[g]), .busy(bz[g]), .count(cnt[g])
`ifdef DEMUX_DISPATCH_STATS_EN
      , .dispatch_cnt(dc[g])
`endif
    );
  end
  function automatic logic [2:0] sv(int k);
    return {s2o[k], s1o[k], s0o[k]};
  endfunction
  task test_reset;
    rst = 1; in_d = 1; in_sel = 3'd5;
    for (int k = 0; k < 3; k++) v[k] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dd[k] !== 1'b0) begin failures++; $display("FAIL reset_d[%0d] got=%b exp=0", k, dd[k]); end
      checks++; if (sv(k) !== 3'b000) begin failures++; $display("FAIL reset_s[%0d] got=%b exp=000", k, sv(k)); end
      checks++; if (cnt[k] !== 3'd0) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, cnt[k]); end
      checks++; if (bz[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, bz[k]); end
      checks++; if (rdy[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, rdy[k]); end
    end
    rst = 0;
    for (int k = 0; k < 3; k++) v[k] = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (rdy[k] !== 1'b1) begin failures++; $display("FAIL release_ready[%0d] got=%b exp=1", k, rdy[k]); end
      checks++; if (cnt[k] !== 3'd0) begin failures++; $display("FAIL release_count[%0d] got=%0d exp=0", k, cnt[k]); end
    end
  endtask
  task test_single;
    v[0] = 1; in_d = 1; in_sel = 3'd5;
    @(negedge clk);
    v[0] = 0;
    checks++; if (cnt[0] !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", cnt[0]); end
    checks++; if (dd[0] !== 1'b0) begin failures++; $display("FAIL single_d_early got=%b exp=0", dd[0]); end
    @(negedge clk);
    checks++; if (dd[0] !== 1'b1) begin failures++; $display("FAIL single_d_pulse got=%b exp=1", dd[0]); end
    checks++; if (sv(0) !== 3'b101) begin failures++; $display("FAIL single_s_pulse got=%b exp=101", sv(0)); end
    checks++; if (cnt[0] !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", cnt[0]); end
    checks++; if (bz[0] !== 1'b1) begin failures++; $display("FAIL single_busy_drive got=%b exp=1", bz[0]); end
    @(negedge clk);
    checks++; if (dd[0] !== 1'b0) begin failures++; $display("FAIL single_d_gap got=%b exp=0", dd[0]); end
    checks++; if (sv(0) !== 3'b101) begin failures++; $display("FAIL single_s_gap got=%b exp=101", sv(0)); end
    checks++; if (bz[0] !== 1'b1) begin failures++; $display("FAIL single_busy_gap got=%b exp=1", bz[0]); end
    @(negedge clk);
    checks++; if (bz[0] !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", bz[0]); end
    checks++; if (sv(0) !== 3'b101) begin failures++; $display("FAIL single_s_idle got=%b exp=101", sv(0)); end
  endtask
  task test_back_to_back;
    logic [2:0] exp_s[3];
    exp_s[0] = 3'd7; exp_s[1] = 3'd6; exp_s[2] = 3'd3;
    v[1] = 1; in_d = 1; in_sel = exp_s[0];
    @(negedge clk);
    checks++; if (dd[1] !== 1'b0) begin failures++; $display("FAIL b2b_d_early got=%b exp=0", dd[1]); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) in_sel = exp_s[i + 1];
      else v[1] = 0;
      @(negedge clk);
      checks++; if (dd[1] !== 1'b1) begin failures++; $display("FAIL b2b_d[%0d] got=%b exp=1", i, dd[1]); end
      checks++; if (sv(1) !== exp_s[i]) begin failures++; $display("FAIL b2b_s[%0d] got=%b exp=%b", i, sv(1), exp_s[i]); end
    end
    @(negedge clk);
    checks++; if (dd[1] !== 1'b0) begin failures++; $display("FAIL b2b_d_end got=%b exp=0", dd[1]); end
    checks++; if (sv(1) !== 3'd3) begin failures++; $display("FAIL b2b_s_end got=%b exp=011", sv(1)); end
    checks++; if (bz[1] !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", bz[1]); end
  endtask
  task test_fill;
    logic [2:0] got[5];
    int i, n;
    logic full_seen, held;
    i = 0; n = 0; full_seen = 0; held = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (dd[2] === 1'b1) begin
        if (n < 5) got[n] = sv(2);
        n++;
      end
      if (cnt[2] === 3'd4) begin
        full_seen = 1;
        checks++; if (rdy[2] !== 1'b0) begin failures++; $display("FAIL fill_ready_full got=%b exp=0", rdy[2]); end
      end
      if (i < 6) begin
        v[2] = 1; in_d = (i != 0); in_sel = (i == 0) ? 3'd7 : 3'(i - 1);
        if (i == 5 && rdy[2] !== 1'b1) held = 1;
        if (rdy[2] === 1'b1) i++;
      end else v[2] = 0;
    end
    v[2] = 0;
    checks++; if (n != 5) begin failures++; $display("FAIL fill_pulses got=%0d exp=5", n); end
    checks++; if (i != 6) begin failures++; $display("FAIL fill_accepted got=%0d exp=6", i); end
    checks++; if (!full_seen) begin failures++; $display("FAIL fill_full_seen got=0 exp=1"); end
    checks++; if (!held) begin failures++; $display("FAIL fill_fifth_held got=0 exp=1"); end
    for (int k = 0; k < 5 && k < n; k++) begin
      checks++; if (got[k] !== 3'(k)) begin failures++; $display("FAIL fill_order[%0d] got=%0d exp=%0d", k, got[k], k); end
    end
  endtask
  task test_rst_mid;
    int c, pulses;
    c = 0;
    while (bz[2] !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    checks++; if (bz[2] !== 1'b0) begin failures++; $display("FAIL rstmid_idle_timeout got=%b exp=0", bz[2]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v[2] = 1; in_d = 1; in_sel = 3'(i + 1);
    end
    @(negedge clk);
    v[2] = 0;
    @(negedge clk);
    checks++; if (cnt[2] !== 3'd4) begin failures++; $display("FAIL rstmid_count_full got=%0d exp=4", cnt[2]); end
    checks++; if (rdy[2] !== 1'b0) begin failures++; $display("FAIL rstmid_ready_full got=%b exp=0", rdy[2]); end
    @(negedge clk);
    checks++; if (dd[2] !== 1'b1) begin failures++; $display("FAIL rstmid_drive_d got=%b exp=1", dd[2]); end
    checks++; if (sv(2) !== 3'd2) begin failures++; $display("FAIL rstmid_drive_s got=%b exp=010", sv(2)); end
    checks++; if (cnt[2] !== 3'd3) begin failures++; $display("FAIL rstmid_drive_count got=%0d exp=3", cnt[2]); end
    rst = 1;
    @(negedge clk);
    checks++; if (dd[2] !== 1'b0) begin failures++; $display("FAIL rstmid_d got=%b exp=0", dd[2]); end
    checks++; if (sv(2) !== 3'd0) begin failures++; $display("FAIL rstmid_s got=%b exp=000", sv(2)); end
    checks++; if (cnt[2] !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", cnt[2]); end
    checks++; if (bz[2] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bz[2]); end
    rst = 0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (dd[2] !== 1'b0) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_no_pulses got=%0d exp=0", pulses); end
    checks++; if (cnt[2] !== 3'd0) begin failures++; $display("FAIL rstmid_count_after got=%0d exp=0", cnt[2]); end
  endtask
`ifdef DEMUX_DISPATCH_STATS_EN
  task test_stats;
    checks++; if (dc[1] !== 8'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", dc[1]); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v[1] = 1; in_d = i[0]; in_sel = i[2:0];
    end
    @(negedge clk);
    v[1] = 0;
    repeat (3) @(negedge clk);
    checks++; if (dc[1] !== 8'd255) begin failures++; $display("FAIL stats_saturate got=%0d exp=255", dc[1]); end
  endtask
`endif
  initial begin
    for (int k = 0; k < 3; k++) v[k] = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_fill;
    test_rst_mid;
`ifdef DEMUX_DISPATCH_STATS_EN
    test_stats;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=expired exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
